// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, frame width and tick-divisor helper.
package uart_pkg;
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    function automatic int calc_div(input int clk_freq, input int baud_rate, input int oversample);
        return (clk_freq / (baud_rate * oversample) < 1) ? 1 : clk_freq / (baud_rate * oversample);
    endfunction
endpackage

// File: rtl/uart_os_tick.sv
// uart_os_tick: oversample tick divisor; clr holds the count at 0 so tick phase follows its release.
module uart_os_tick #(
    parameter int DIV = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    assign tick = !clr && r_cnt == LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clr || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampled 8N1 UART receiver with 3-sample majority vote per bit.
// Define UART_RX_PARITY_EN to receive an even-parity bit and drive parity_err.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int clk_freq   = 1000000,
    parameter int baud_rate  = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 done,
    output logic                 busy,
    output logic                 frame_err
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 parity_err
`endif
);
    localparam int DIV = calc_div(clk_freq, baud_rate, OVERSAMPLE);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] S_PRE  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

    rx_state_t            r_state;
    logic [1:0]           r_sync;
    logic [SW-1:0]        r_samp;
    logic [2:0]           r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic [1:0]           r_vote;
`ifdef UART_RX_PARITY_EN
    logic                 r_par;
`endif
    logic w_rx_s, w_tick, w_clr, w_decide, w_end, w_maj;

    assign w_rx_s   = r_sync[1];
    assign w_clr    = r_state == ST_IDLE || r_state == ST_WAIT_HIGH;
    assign w_decide = w_tick && r_samp == S_DEC;
    assign w_end    = w_tick && r_samp == S_LAST;
    assign w_maj    = (r_vote[1] & r_vote[0]) | (w_rx_s & (r_vote[1] | r_vote[0]));
    assign busy     = r_state != ST_IDLE;

    uart_os_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (w_clr),
        .tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
            r_samp <= '0;
            r_vote <= '0;
        end else begin
            r_sync <= {r_sync[0], rx};
            r_samp <= w_clr ? '0 : w_tick ? r_samp + SW'(1) : r_samp;
            if (w_tick && (r_samp == S_PRE || r_samp == S_MID))
                r_vote <= {r_vote[0], w_rx_s};
        end
    end

    // The stop bit is resolved at its midpoint so a following start edge is never missed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_bit     <= '0;
            r_shift   <= '0;
            dout      <= '0;
            done      <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE:
                    if (!w_rx_s)
                        r_state <= ST_START;
                ST_START:
                    if (w_decide && w_maj)
                        r_state <= ST_IDLE;
                    else if (w_end) begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                    end
                ST_DATA: begin
                    if (w_decide)
                        r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
                    if (w_end) begin
                        r_bit <= r_bit + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (r_bit == 3'(DATA_BITS - 1))
                            r_state <= ST_PARITY;
`else
                        if (r_bit == 3'(DATA_BITS - 1))
                            r_state <= ST_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_decide)
                        r_par <= w_maj;
                    if (w_end)
                        r_state <= ST_STOP;
                end
`endif
                ST_STOP:
                    if (w_decide) begin
                        dout      <= r_shift;
                        done      <= 1'b1;
                        frame_err <= !w_maj;
`ifdef UART_RX_PARITY_EN
                        parity_err <= ^{r_shift, r_par};
`endif
                        r_state   <= w_maj ? ST_IDLE : ST_WAIT_HIGH;
                    end
                ST_WAIT_HIGH:
                    if (w_rx_s)
                        r_state <= ST_IDLE;
                default:
                    r_state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed table, corner sequences and random frames against a frame-level model.
module tb_uart_rx_os;
`ifdef UART_RX_PARITY_EN
    localparam int LAT_LO = 996, LAT_HI = 1056;
`else
    localparam int LAT_LO = 900, LAT_HI = 960;
`endif

    typedef struct {
        logic [7:0] dout;
        logic       ferr;
        logic       perr;
        logic       busy;
        int         cyc;
    } rec_t;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         bp;
        logic       flip;
        logic [7:0] exp_dout;
        logic       exp_ferr;
        logic       exp_perr;
    } vec_t;

    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    logic [7:0] dout;
    logic done, busy, frame_err, perr;
    int cyc = 0, checks = 0, failures = 0;
    rec_t q_got[$], q_exp[$];
    vec_t vecs[8];

`ifdef UART_RX_PARITY_EN
    logic parity_err;
    assign perr = parity_err;
`else
    assign perr = 1'b0;
`endif

    uart_rx_os dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .dout     (dout),
        .done     (done),
        .busy     (busy),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) q_got.push_back('{dout, frame_err, perr, busy, cyc});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Frame-level model: the byte comes back unchanged, a low stop bit flags a frame error
    // and keeps the receiver busy, a wrong parity bit flags a parity error.
    function automatic rec_t model(input logic [7:0] b, input logic stop, input logic flip, input int t0);
        return '{b, !stop, flip, !stop, t0};
    endfunction

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int bp, input logic flip,
                              input int abort, output int t0);
        logic [10:0] f;
        int nb;
`ifdef UART_RX_PARITY_EN
        f = {stop, ^b ^ flip, b, 1'b0};
        nb = 11;
`else
        f = {1'b0, stop, b, 1'b0};
        nb = 10;
`endif
        t0 = cyc;
        for (int i = 0; i < nb; i++) begin
            rx = f[i];
            for (int k = 0; k < bp; k++) begin
                if (abort > 0 && i * bp + k == abort) begin
                    rst_n = 1'b0;
                    rx = 1'b1;
                    return;
                end
                @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string name);
        rec_t e, g;
        int n = 0;
        while (q_got.size() < q_exp.size() && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (200) @(negedge clk);
        chk({name, "_count"}, q_got.size(), q_exp.size());
        while (q_exp.size() > 0 && q_got.size() > 0) begin
            e = q_exp.pop_front();
            g = q_got.pop_front();
            chk({name, "_dout"}, g.dout, e.dout);
            chk({name, "_ferr"}, g.ferr, e.ferr);
            chk({name, "_busy"}, g.busy, e.busy);
`ifdef UART_RX_PARITY_EN
            chk({name, "_perr"}, g.perr, e.perr);
`endif
            chk_rng({name, "_lat"}, g.cyc - e.cyc, LAT_LO, LAT_HI);
        end
        q_got.delete();
        q_exp.delete();
    endtask

    initial begin
        int t0;
        logic [7:0] b;
        logic s, fl;
        int bp;
        vecs[0] = '{8'hA5, 1'b1, 96, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b1, 96, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[2] = '{8'h80, 1'b1, 93, 1'b0, 8'h80, 1'b0, 1'b0};
        vecs[3] = '{8'hC3, 1'b1, 99, 1'b0, 8'hC3, 1'b0, 1'b0};
        vecs[4] = '{8'h55, 1'b0, 96, 1'b0, 8'h55, 1'b1, 1'b0};
        vecs[5] = '{8'hAA, 1'b1, 96, 1'b0, 8'hAA, 1'b0, 1'b0};
        vecs[6] = '{8'h07, 1'b1, 96, 1'b0, 8'h07, 1'b0, 1'b0};
        vecs[7] = '{8'h07, 1'b1, 96, 1'b1, 8'h07, 1'b0, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 8'h00);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ferr", frame_err, 1'b0);
        chk("rst_perr", perr, 1'b0);
        rst_n = 1'b1;
        idle(20);

        for (int i = 0; i < 8; i++) begin
            send_frame(vecs[i].data, vecs[i].stop, vecs[i].bp, vecs[i].flip, 0, t0);
            q_exp.push_back('{vecs[i].exp_dout, vecs[i].exp_ferr, vecs[i].exp_perr, vecs[i].exp_ferr, t0});
            idle(30);
            drain($sformatf("vec%0d", i));
        end

        rx = 1'b0;
        repeat (20) @(negedge clk);
        chk("glitch_busy_start", busy, 1'b1);
        repeat (10) @(negedge clk);
        rx = 1'b1;
        repeat (50) @(negedge clk);
        chk("glitch_busy_mid", busy, 1'b0);
        drain("glitch");

        send_frame(8'h3C, 1'b0, 96, 1'b0, 0, t0);
        q_exp.push_back(model(8'h3C, 1'b0, 1'b0, t0));
        rx = 1'b0;
        repeat (200) @(negedge clk);
        chk("break_busy_low", busy, 1'b1);
        chk("break_one_done", q_got.size(), 1);
        idle(20);
        chk("break_busy_high", busy, 1'b0);
        send_frame(8'h81, 1'b1, 96, 1'b0, 0, t0);
        q_exp.push_back(model(8'h81, 1'b1, 1'b0, t0));
        idle(30);
        drain("break");

        send_frame(8'h00, 1'b1, 96, 1'b0, 0, t0);
        q_exp.push_back(model(8'h00, 1'b1, 1'b0, t0));
        send_frame(8'hFF, 1'b1, 99, 1'b0, 0, t0);
        q_exp.push_back(model(8'hFF, 1'b1, 1'b0, t0));
        idle(30);
        drain("b2b");

        send_frame(8'hE7, 1'b1, 96, 1'b0, 5 * 96 + 40, t0);
        @(negedge clk);
        chk("arst_dout", dout, 8'h00);
        chk("arst_done", done, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ferr", frame_err, 1'b0);
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        idle(50);
        send_frame(8'h5A, 1'b1, 96, 1'b0, 0, t0);
        q_exp.push_back(model(8'h5A, 1'b1, 1'b0, t0));
        idle(30);
        drain("arst");

        for (int i = 0; i < 16; i++) begin
            b  = 8'($urandom);
            s  = ($urandom_range(0, 5) != 0);
            fl = 1'($urandom);
            bp = $urandom_range(93, 99);
            send_frame(b, s, bp, fl, 0, t0);
            q_exp.push_back(model(b, s, fl, t0));
            idle(s ? $urandom_range(0, 40) : $urandom_range(5, 40));
        end
        idle(30);
        drain("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
